// File: rtl/riscv_dcache_ctrl.sv
// ============================================================================
// riscv_dcache_ctrl
// ----------------------------------------------------------------------------
// Write-back, write-allocate data-cache controller FSM.
//   IDLE       : serve hits with zero latency; a miss starts a line transfer.
//   WRITE_BACK : the victim line is dirty and is written back (old tag).
//   ALLOCATE   : the new line is read from memory (CPU tag) and refilled.
//   UPDATE     : one settle cycle, then IDLE replays the request as a hit.
// Only the state is registered. All other outputs are decoded
// combinationally from the state and the inputs.
//
// Configuration macro:
//   DCACHE_PERF_CNT_EN - when defined, saturating hit and miss counters are
//                        built. When undefined, hit_cnt and miss_cnt are
//                        tied to zero and no counter flops exist.
// ============================================================================
module riscv_dcache_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_rd_req,
    input  logic             cpu_wr_req,
    input  logic             hit,
    input  logic             dirty,
    input  logic             mem_ready,
    output logic             stall,
    output logic             replace_tag,
    output logic             dirty_in,
    output logic             valid_in,
    output logic             data_wr_en,
    output logic             refill_en,
    output logic             mem_rd_req,
    output logic             mem_wr_req,
    output logic             mem_addr_sel,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WRITE_BACK = 2'd1;
    localparam logic [1:0] ALLOCATE   = 2'd2;
    localparam logic [1:0] UPDATE     = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       req;
    logic       is_store;

    // A request is a load or a store. When both are high, the request is
    // handled as a store. The request is masked while reset is held, so no
    // output can assert then: the state is already IDLE, and only the IDLE
    // decode looks at the request.
    assign req      = rst & (cpu_rd_req | cpu_wr_req);
    assign is_store = cpu_wr_req;

    // State register with asynchronous clear to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case leaves a signal unassigned (which would infer a latch).
        state_nxt    = state;
        stall        = 1'b0;
        replace_tag  = 1'b0;
        dirty_in     = 1'b0;
        valid_in     = 1'b0;
        data_wr_en   = 1'b0;
        refill_en    = 1'b0;
        mem_rd_req   = 1'b0;
        mem_wr_req   = 1'b0;
        mem_addr_sel = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // A store hit updates the data array and marks the
                        // line dirty in the same cycle. A load hit needs
                        // nothing beyond stall staying low.
                        if (is_store) begin
                            data_wr_en  = 1'b1;
                            replace_tag = 1'b1;
                            valid_in    = 1'b1;
                            dirty_in    = 1'b1;
                        end
                    end else begin
                        stall     = 1'b1;
                        state_nxt = dirty ? WRITE_BACK : ALLOCATE;
                    end
                end
            end

            WRITE_BACK: begin
                stall        = 1'b1;
                mem_wr_req   = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    state_nxt = ALLOCATE;
                end
            end

            ALLOCATE: begin
                stall      = 1'b1;
                mem_rd_req = 1'b1;
                if (mem_ready) begin
                    // The refilled line is clean. A pending store dirties
                    // it when it is replayed from IDLE.
                    refill_en   = 1'b1;
                    replace_tag = 1'b1;
                    valid_in    = 1'b1;
                    dirty_in    = 1'b0;
                    state_nxt   = UPDATE;
                end
            end

            UPDATE: begin
                stall     = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic             first_after_upd;
    logic             hit_evt;
    logic             miss_evt;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    // The first IDLE cycle after UPDATE is the replay of the miss that was
    // just serviced. It is already counted as a miss, so it is not a hit.
    assign hit_evt  = (state == IDLE) && req && hit && !first_after_upd;
    assign miss_evt = (state == IDLE) && req && !hit;

    // Marks the IDLE cycle that directly follows UPDATE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_after_upd <= 1'b0;
        end else begin
            first_after_upd <= (state == UPDATE);
        end
    end

    // Saturating hit and miss counters, held at zero during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
            if (miss_evt && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_dcache_ctrl.sv
// ============================================================================
// tb_riscv_dcache_ctrl
// ----------------------------------------------------------------------------
// Directed per-cycle vectors for the data-cache controller. The driver applies
// the inputs for one cycle and queues the outputs expected in that cycle. A
// monitor pops the queue on each falling edge and compares the outputs.
// The counters are narrowed to 4 bits so that saturation is reached by real
// misses and hits. The counter expectations follow DCACHE_PERF_CNT_EN.
// ============================================================================
`timescale 1ns/1ps
module tb_riscv_dcache_ctrl;

    localparam int CW = 4;
`ifdef DCACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output bit order:
    // {stall, replace_tag, dirty_in, valid_in, data_wr_en,
    //  refill_en, mem_rd_req, mem_wr_req, mem_addr_sel}
    localparam logic [8:0] O_NONE    = 9'b000000000;
    localparam logic [8:0] O_ST_HIT  = 9'b011110000;
    localparam logic [8:0] O_MISS    = 9'b100000000;
    localparam logic [8:0] O_WB      = 9'b100000011;
    localparam logic [8:0] O_AL      = 9'b100000100;
    localparam logic [8:0] O_AL_DONE = 9'b110101100;
    localparam logic [8:0] O_UPD     = 9'b100000000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_rd_req, cpu_wr_req, hit, dirty, mem_ready;
    logic          stall, replace_tag, dirty_in, valid_in, data_wr_en;
    logic          refill_en, mem_rd_req, mem_wr_req, mem_addr_sel;
    logic [CW-1:0] hit_cnt, miss_cnt;
    logic [8:0]    outs;

    typedef struct {
        string         name;
        logic [8:0]    outs;
        logic [CW-1:0] hc;
        logic [CW-1:0] mc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] exp_hit  = '0;
    logic [CW-1:0] exp_miss = '0;

    riscv_dcache_ctrl #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_rd_req   (cpu_rd_req),
        .cpu_wr_req   (cpu_wr_req),
        .hit          (hit),
        .dirty        (dirty),
        .mem_ready    (mem_ready),
        .stall        (stall),
        .replace_tag  (replace_tag),
        .dirty_in     (dirty_in),
        .valid_in     (valid_in),
        .data_wr_en   (data_wr_en),
        .refill_en    (refill_en),
        .mem_rd_req   (mem_rd_req),
        .mem_wr_req   (mem_wr_req),
        .mem_addr_sel (mem_addr_sel),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    assign outs = {stall, replace_tag, dirty_in, valid_in, data_wr_en,
                   refill_en, mem_rd_req, mem_wr_req, mem_addr_sel};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
        end
    endtask

    // Monitor: compares the outputs presented mid-cycle with the next queued
    // expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.name, "/outs"}, 32'(outs), 32'(mon_e.outs));
            check({mon_e.name, "/hit_cnt"}, 32'(hit_cnt), 32'(mon_e.hc));
            check({mon_e.name, "/miss_cnt"}, 32'(miss_cnt), 32'(mon_e.mc));
        end
    end

    // Drives one cycle, queues its expected outputs and advances the
    // counter model (the counters update at the end of the cycle).
    task automatic cyc(input string name, input logic r, input logic rd, input logic wr,
                       input logic h, input logic d, input logic mr,
                       input logic [8:0] eo, input bit ih, input bit im);
        @(posedge clk);
        #1;
        rst = r; cpu_rd_req = rd; cpu_wr_req = wr; hit = h; dirty = d; mem_ready = mr;
        if (!r) begin
            exp_hit  = '0;
            exp_miss = '0;
        end
        sb.push_back('{name, eo, exp_hit, exp_miss});
        if (PERF && r && ih && (exp_hit != '1))  exp_hit  = exp_hit + 1'b1;
        if (PERF && r && im && (exp_miss != '1)) exp_miss = exp_miss + 1'b1;
    endtask

    initial begin
        rst = 1'b0; cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
        hit = 1'b0; dirty = 1'b0; mem_ready = 1'b0;

        // Reset: outputs stay quiet even with a miss or hit request present.
        cyc("rst_miss_req",   0, 1, 1, 0, 1, 1, O_NONE, 0, 0);
        cyc("rst_hit_req",    0, 1, 0, 1, 0, 0, O_NONE, 0, 0);
        cyc("idle_noreq",     1, 0, 0, 0, 0, 0, O_NONE, 0, 0);
        cyc("idle_mready",    1, 0, 0, 1, 1, 1, O_NONE, 0, 0);

        // Load hit, store hit, and load+store treated as a store.
        cyc("load_hit",       1, 1, 0, 1, 0, 0, O_NONE,   1, 0);
        cyc("store_hit",      1, 0, 1, 1, 0, 0, O_ST_HIT, 1, 0);
        cyc("both_hit",       1, 1, 1, 1, 1, 0, O_ST_HIT, 1, 0);
        cyc("idle_after_hit", 1, 0, 0, 0, 0, 1, O_NONE,   0, 0);

        // Dirty load miss: write-back for 4 cycles, refill for 5, update for 1.
        cyc("ld_miss_idle",   1, 1, 0, 0, 1, 0, O_MISS, 0, 1);
        for (int i = 0; i < 3; i++) cyc("wb_wait", 1, 1, 0, 1, 1, 0, O_WB, 0, 0);
        cyc("wb_done",        1, 1, 0, 0, 1, 1, O_WB, 0, 0);
        for (int i = 0; i < 4; i++) cyc("al_wait", 1, 1, 0, 0, 1, 0, O_AL, 0, 0);
        cyc("al_done",        1, 1, 0, 0, 1, 1, O_AL_DONE, 0, 0);
        cyc("upd_mready",     1, 1, 0, 0, 0, 1, O_UPD, 0, 0);
        cyc("ld_replay_hit",  1, 1, 0, 1, 0, 0, O_NONE, 0, 0);
        cyc("ld_second_hit",  1, 1, 0, 1, 0, 0, O_NONE, 1, 0);

        // Clean store miss: no write-back, clean refill, then the store hits.
        cyc("st_miss_idle",   1, 0, 1, 0, 0, 0, O_MISS, 0, 1);
        cyc("st_al_wait0",    1, 0, 1, 0, 0, 0, O_AL, 0, 0);
        cyc("st_al_wait1",    1, 0, 1, 0, 0, 0, O_AL, 0, 0);
        cyc("st_al_done",     1, 0, 1, 0, 0, 1, O_AL_DONE, 0, 0);
        cyc("st_upd",         1, 0, 1, 0, 0, 0, O_UPD, 0, 0);
        cyc("st_replay_hit",  1, 0, 1, 1, 0, 0, O_ST_HIT, 0, 0);

        // A request dropped mid-miss still runs the sequence to completion.
        cyc("abort_idle",     1, 1, 0, 0, 0, 0, O_MISS, 0, 1);
        cyc("abort_al_noreq", 1, 0, 0, 0, 0, 0, O_AL, 0, 0);
        cyc("abort_al_done",  1, 0, 0, 0, 0, 1, O_AL_DONE, 0, 0);
        cyc("abort_upd",      1, 0, 0, 0, 0, 0, O_UPD, 0, 0);
        cyc("abort_idle_end", 1, 0, 0, 0, 0, 1, O_NONE, 0, 0);

        // Reset asserted mid-cycle during write-back. The monitor samples
        // before any clock edge follows, so the outputs must already be 0.
        cyc("arst_miss",      1, 1, 0, 0, 1, 0, O_MISS, 0, 1);
        cyc("arst_wb",        1, 1, 0, 0, 1, 0, O_WB, 0, 0);
        @(posedge clk);
        #1;
        #2 rst = 1'b0;
        exp_hit  = '0;
        exp_miss = '0;
        sb.push_back('{"arst_drop", O_NONE, exp_hit, exp_miss});
        cyc("arst_hold",      0, 1, 0, 0, 1, 1, O_NONE, 0, 0);
        // After release, a clean miss must start from IDLE with no write-back.
        cyc("arst_rel_miss",  1, 1, 0, 0, 0, 0, O_MISS, 0, 1);
        cyc("arst_al_done",   1, 1, 0, 0, 0, 1, O_AL_DONE, 0, 0);
        cyc("arst_upd",       1, 1, 0, 0, 0, 0, O_UPD, 0, 0);

        // Saturation: drive both counters past all-ones.
        for (int i = 0; i < 17; i++) begin
            cyc("sat_miss",    1, 1, 0, 0, 0, 0, O_MISS, 0, 1);
            cyc("sat_al_done", 1, 1, 0, 0, 0, 1, O_AL_DONE, 0, 0);
            cyc("sat_upd",     1, 1, 0, 0, 0, 0, O_UPD, 0, 0);
            cyc("sat_replay",  1, 1, 0, 1, 0, 0, O_NONE, 0, 0);
            cyc("sat_hit",     1, 1, 0, 1, 0, 0, O_NONE, 1, 0);
        end
        cyc("sat_final",      1, 0, 0, 0, 0, 0, O_NONE, 0, 0);

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_dcache_ctrl.md
RISCV_DCACHE_CTRL -- requirements
Module: riscv_dcache_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of each performance counter.
REQ-002 SHALL have port clk  input  1  clock; state updates on the positive edge (the tag array writes on the negative edge).
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cpu_rd_req  input  1  CPU load request.
REQ-005 SHALL have port cpu_wr_req  input  1  CPU store request.
REQ-006 SHALL have port hit  input  1  tag-array hit flag.
REQ-007 SHALL have port dirty  input  1  tag-array dirty flag.
REQ-008 SHALL have port mem_ready  input  1  memory completed the current line transfer.
REQ-009 SHALL have port stall  output  1  CPU pipeline stall.
REQ-010 SHALL have port replace_tag  output  1  tag-array write enable.
REQ-011 SHALL have port dirty_in  output  1  dirty bit to the tag array.
REQ-012 SHALL have port valid_in  output  1  valid bit to the tag array.
REQ-013 SHALL have port data_wr_en  output  1  data-array store write enable.
REQ-014 SHALL have port refill_en  output  1  data-array line refill write enable.
REQ-015 SHALL have port mem_rd_req  output  1  line read request to memory.
REQ-016 SHALL have port mem_wr_req  output  1  line write-back request to memory.
REQ-017 SHALL have port mem_addr_sel  output  1  memory address tag: 1 = old tag, 0 = CPU tag.
REQ-018 SHALL have port hit_cnt  output  CNT_W  hit count.
REQ-019 SHALL have port miss_cnt  output  CNT_W  miss count.

Function
REQ-020 SHALL implement states IDLE, WRITE_BACK, ALLOCATE and UPDATE, with the state held in a posedge register; all other outputs SHALL be combinational from state and inputs.
REQ-021 A request SHALL be cpu_rd_req OR cpu_wr_req; when both are high, the request SHALL be treated as a store.
REQ-022 IDLE with no request: all outputs 0; remain in IDLE.
REQ-023 IDLE, load with hit=1: stall=0, zero-cycle latency; remain in IDLE.
REQ-024 IDLE, store with hit=1: stall=0, data_wr_en=1, replace_tag=1, valid_in=1, dirty_in=1; remain in IDLE.
REQ-025 IDLE, request with hit=0 and dirty=1: stall=1; next state WRITE_BACK.
REQ-026 IDLE, request with hit=0 and dirty=0: stall=1; next state ALLOCATE.
REQ-027 WRITE_BACK: stall=1, mem_wr_req=1, mem_addr_sel=1; on mem_ready=1 go to ALLOCATE, otherwise hold.
REQ-028 ALLOCATE: stall=1, mem_rd_req=1, mem_addr_sel=0.
REQ-029 ALLOCATE with mem_ready=1 SHALL additionally drive refill_en=1, replace_tag=1, valid_in=1 and dirty_in=0, then go to UPDATE.
REQ-030 UPDATE: stall=1 for exactly one cycle, then IDLE, where the pending request is re-evaluated and now hits.
REQ-031 mem_ready SHALL be ignored in IDLE and UPDATE.
REQ-032 A request deasserted mid-miss SHALL NOT abort the transfer; the FSM SHALL complete the sequence to IDLE.
REQ-033 Miss latency SHALL be the write-back wait plus the refill wait plus 2 cycles.

Reset
REQ-034 rst=0 SHALL force IDLE immediately, asynchronously.
REQ-035 While rst=0, all 1-bit outputs SHALL be 0, including mem_rd_req and mem_wr_req, which SHALL withdraw mid-transfer.
REQ-036 While rst=0, hit_cnt and miss_cnt SHALL be 0.

Configuration
REQ-037 Macro DCACHE_PERF_CNT_EN SHALL control the performance counters.
REQ-038 When defined: miss_cnt SHALL increment on each IDLE-to-WRITE_BACK or IDLE-to-ALLOCATE transition.
REQ-039 When defined: hit_cnt SHALL increment on each IDLE cycle with a request and hit=1, excluding the first IDLE cycle after UPDATE.
REQ-040 When defined: both counters SHALL saturate at all-ones.
REQ-041 When undefined: hit_cnt and miss_cnt ports SHALL exist, SHALL be tied to 0, and SHALL have no counter flops.

Verification
REQ-042 Reset, then load with hit=1 -> stall=0 in the same cycle; state stays IDLE; hit_cnt=1.
REQ-043 Store with hit=1 -> data_wr_en=1, replace_tag=1, dirty_in=1, valid_in=1 for 1 cycle; stall=0.
REQ-044 Load with hit=0, dirty=1, mem_ready pulsed after 3 and then 4 cycles -> mem_wr_req for 4 cycles with mem_addr_sel=1, then mem_rd_req for 5 cycles, refill_en=1 on the last, UPDATE for 1 cycle; stall total 11 cycles; miss_cnt=1, hit_cnt unchanged.
REQ-045 Store with hit=0, dirty=0, mem_ready after 2 cycles -> no mem_wr_req; refill writes dirty_in=0; then in IDLE the store hits and writes dirty_in=1.
REQ-046 rst=0 asserted during WRITE_BACK -> mem_wr_req drops without waiting for a clock; after release, state is IDLE and counters are 0.
REQ-047 With the macro defined and miss_cnt preloaded to all-ones by forcing, one more miss -> value stays all-ones; with the macro undefined -> both counters read 0 throughout.
